// File: rtl/core_pkg.sv
// Shared widths and bus bundles for the rename register file.
// Defaults here seed the parameters of the rename file and its read ports.
package core_pkg;

    localparam int NREG_D    = 256;
    localparam int DATA_W_D  = 32;
    localparam int TAG_W_D   = 64;
    localparam int NREAD_D   = 2;
    localparam int NCOMP_D   = 2;
    localparam int NCOMMIT_D = 1;
    localparam int LW_D      = $clog2(NREG_D);

    typedef struct packed {
        logic                en;
        logic [LW_D-1:0]     lreg;
        logic [TAG_W_D-1:0]  tag;
        logic [DATA_W_D-1:0] data;
    } CompleteInfo;

    typedef struct packed {
        logic                en;
        logic [LW_D-1:0]     lreg;
        logic [TAG_W_D-1:0]  tag;
        logic [DATA_W_D-1:0] data;
    } CommitInfo;

    typedef struct packed {
        logic                valid;
        logic [DATA_W_D-1:0] data;
        logic [TAG_W_D-1:0]  tag;
    } Source;

endpackage

// File: rtl/rename_register_file_read_port.sv
// One source read port: completion bypass, then rename state, then arch value.
// Ports: src index, established completion hits, selected register state;
// outputs the next-cycle valid/data/tag for this port.
module rename_read_port
    import core_pkg::*;
#(
    parameter int LW       = LW_D,
    parameter int DATA_W   = DATA_W_D,
    parameter int TAG_W    = TAG_W_D,
    parameter int NCOMP    = NCOMP_D,
    parameter int ZERO_REG = 0
) (
    input  logic [LW-1:0]                src,
    input  logic [NCOMP-1:0]             comp_hit,
    input  logic [NCOMP-1:0][LW-1:0]     comp_logic,
    input  logic [NCOMP-1:0][DATA_W-1:0] comp_data,
    input  logic                         place,
    input  logic                         phys_valid,
    input  logic [TAG_W-1:0]             phys_tag,
    input  logic [DATA_W-1:0]            phys_data,
    input  logic [DATA_W-1:0]            arch_data,
    output logic                         valid,
    output logic [DATA_W-1:0]            data,
    output logic [TAG_W-1:0]             tag
);

    always_comb begin
        valid = 1'b1;
        data  = arch_data;
        tag   = phys_tag;
        if (place) begin
            valid = phys_valid;
            data  = phys_data;
        end
        // Descending scan so the lowest-index hit is assigned last.
        for (int k = NCOMP - 1; k >= 0; k--) begin
            if (comp_hit[k] && comp_logic[k] == src) begin
                valid = 1'b1;
                data  = comp_data[k];
            end
        end
        if (ZERO_REG != 0 && src == '0) begin
            valid = 1'b1;
            data  = '0;
        end
    end

endmodule

// File: rtl/rename_register_file.sv
// Renaming register file: arch values plus per-register rename state,
// tag allocation, completion/commit buses and NREAD registered reads.
// Ports: clock, reset, flash; dest_en/dest_logic -> dest_phys; src -> rd_*;
// comp_* completion buses; cmt_* in-order commit buses.
module rename_register_file
    import core_pkg::*;
#(
    parameter int NREG     = NREG_D,
    parameter int DATA_W   = DATA_W_D,
    parameter int TAG_W    = TAG_W_D,
    parameter int NREAD    = NREAD_D,
    parameter int NCOMP    = NCOMP_D,
    parameter int NCOMMIT  = NCOMMIT_D,
    parameter int ZERO_REG = 0,
    localparam int LW      = $clog2(NREG)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           flash,
    input  logic                           dest_en,
    input  logic [LW-1:0]                  dest_logic,
    output logic [TAG_W-1:0]               dest_phys,
    input  logic [NREAD-1:0][LW-1:0]       src,
    input  logic [NCOMP-1:0]               comp_en,
    input  logic [NCOMP-1:0][LW-1:0]       comp_logic,
    input  logic [NCOMP-1:0][TAG_W-1:0]    comp_tag,
    input  logic [NCOMP-1:0][DATA_W-1:0]   comp_data,
    input  logic [NCOMMIT-1:0]             cmt_en,
    input  logic [NCOMMIT-1:0][LW-1:0]     cmt_logic,
    input  logic [NCOMMIT-1:0][TAG_W-1:0]  cmt_tag,
    input  logic [NCOMMIT-1:0][DATA_W-1:0] cmt_data,
    output logic [NREAD-1:0]               rd_valid,
    output logic [NREAD-1:0][DATA_W-1:0]   rd_data,
    output logic [NREAD-1:0][TAG_W-1:0]    rd_tag
);

    logic              place      [NREG];
    logic [DATA_W-1:0] arch_data  [NREG];
    logic              phys_valid [NREG];
    logic [TAG_W-1:0]  phys_tag   [NREG];
    logic [DATA_W-1:0] phys_data  [NREG];
    logic [TAG_W-1:0]  counter;

    logic [NCOMP-1:0]             est;
    logic [NREAD-1:0]             rp_valid;
    logic [NREAD-1:0][DATA_W-1:0] rp_data;
    logic [NREAD-1:0][TAG_W-1:0]  rp_tag;

    function automatic logic is_zr(input logic [LW-1:0] r);
        return (ZERO_REG != 0) && (r == '0);
    endfunction

    // A same-cycle rename of a register overrides commit and completion.
    function automatic logic ren_same(input logic [LW-1:0] r);
        return dest_en && dest_logic == r && !is_zr(r);
    endfunction

    assign dest_phys = counter;

    always_comb begin
        est = '0;
        for (int k = 0; k < NCOMP; k++) begin
            est[k] = comp_en[k] && !is_zr(comp_logic[k])
                  && place[comp_logic[k]]
                  && !phys_valid[comp_logic[k]]
                  && phys_tag[comp_logic[k]] == comp_tag[k];
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_rp
        rename_read_port #(
            .LW       (LW),
            .DATA_W   (DATA_W),
            .TAG_W    (TAG_W),
            .NCOMP    (NCOMP),
            .ZERO_REG (ZERO_REG)
        ) u_rp (
            .src        (src[i]),
            .comp_hit   (est),
            .comp_logic (comp_logic),
            .comp_data  (comp_data),
            .place      (place[src[i]]),
            .phys_valid (phys_valid[src[i]]),
            .phys_tag   (phys_tag[src[i]]),
            .phys_data  (phys_data[src[i]]),
            .arch_data  (arch_data[src[i]]),
            .valid      (rp_valid[i]),
            .data       (rp_data[i]),
            .tag        (rp_tag[i])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                place[r]      <= 1'b0;
                arch_data[r]  <= '0;
                phys_valid[r] <= 1'b0;
            end
            counter  <= '0;
            rd_valid <= '0;
            rd_data  <= '0;
            rd_tag   <= '0;
        end else if (flash) begin
            for (int r = 0; r < NREG; r++) begin
                place[r] <= 1'b0;
            end
            for (int j = 0; j < NCOMMIT; j++) begin
                if (cmt_en[j] && !is_zr(cmt_logic[j])) begin
                    arch_data[cmt_logic[j]] <= cmt_data[j];
                end
            end
            counter  <= '0;
            rd_valid <= '0;
        end else begin
            // Ascending so the youngest commit's data lands last.
            for (int j = 0; j < NCOMMIT; j++) begin
                if (cmt_en[j] && !is_zr(cmt_logic[j])) begin
                    arch_data[cmt_logic[j]] <= cmt_data[j];
                    if (place[cmt_logic[j]]
                        && phys_tag[cmt_logic[j]] == cmt_tag[j]
                        && !ren_same(cmt_logic[j])) begin
                        place[cmt_logic[j]] <= 1'b0;
                    end
                end
            end
            for (int k = NCOMP - 1; k >= 0; k--) begin
                if (est[k] && !ren_same(comp_logic[k])) begin
                    phys_valid[comp_logic[k]] <= 1'b1;
                    phys_data[comp_logic[k]]  <= comp_data[k];
                end
            end
            if (dest_en) begin
                if (!is_zr(dest_logic)) begin
                    place[dest_logic]      <= 1'b1;
                    phys_valid[dest_logic] <= 1'b0;
                    phys_tag[dest_logic]   <= counter;
                end
                counter <= counter + 1'b1;
            end
            for (int i = 0; i < NREAD; i++) begin
                rd_valid[i] <= rp_valid[i];
                if (rp_valid[i]) begin
                    rd_data[i] <= rp_data[i];
                end else begin
                    rd_tag[i] <= rp_tag[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_rename_register_file.sv
// Scoreboard bench for rename_register_file with a rule-level model.
// Small config: 16 regs, 4-bit tags, reg 0 hardwired, two commit ports.
module tb_rename_register_file;

    localparam int NREG = 16;
    localparam int LW   = 4;
    localparam int DW   = 32;
    localparam int TW   = 4;

    logic                   clock = 1'b0;
    logic                   reset = 1'b0;
    logic                   flash = 1'b0;
    logic                   dest_en = 1'b0;
    logic [LW-1:0]          dest_logic = '0;
    logic [TW-1:0]          dest_phys;
    logic [1:0][LW-1:0]     src = '0;
    logic [1:0]             comp_en = '0;
    logic [1:0][LW-1:0]     comp_logic = '0;
    logic [1:0][TW-1:0]     comp_tag = '0;
    logic [1:0][DW-1:0]     comp_data = '0;
    logic [1:0]             cmt_en = '0;
    logic [1:0][LW-1:0]     cmt_logic = '0;
    logic [1:0][TW-1:0]     cmt_tag = '0;
    logic [1:0][DW-1:0]     cmt_data = '0;
    logic [1:0]             rd_valid;
    logic [1:0][DW-1:0]     rd_data;
    logic [1:0][TW-1:0]     rd_tag;

    rename_register_file #(
        .NREG(NREG), .DATA_W(DW), .TAG_W(TW), .NREAD(2),
        .NCOMP(2), .NCOMMIT(2), .ZERO_REG(1)
    ) dut (
        .clock(clock), .reset(reset), .flash(flash),
        .dest_en(dest_en), .dest_logic(dest_logic), .dest_phys(dest_phys),
        .src(src),
        .comp_en(comp_en), .comp_logic(comp_logic),
        .comp_tag(comp_tag), .comp_data(comp_data),
        .cmt_en(cmt_en), .cmt_logic(cmt_logic),
        .cmt_tag(cmt_tag), .cmt_data(cmt_data),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_tag(rd_tag)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0] v;
        logic [DW-1:0] d [2];
        logic [TW-1:0] t [2];
    } exp_t;

    exp_t q[$];
    int n_checks = 0;
    int n_pass = 0;

    // Reference model: the register file as plain arrays.
    logic          m_place [NREG];
    logic [DW-1:0] m_arch  [NREG];
    logic          m_pv    [NREG];
    logic [TW-1:0] m_ptag  [NREG];
    logic [DW-1:0] m_pdata [NREG];
    logic [TW-1:0] m_cnt;
    logic [1:0]    m_rv;
    logic [DW-1:0] m_rd [2];
    logic [TW-1:0] m_rt [2];

    task automatic check(input string name, input logic ok,
                         input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, req);
    endtask

    task automatic model_cycle();
        logic [1:0] est;
        logic [DW-1:0] val;
        logic vv;
        exp_t e;
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                m_place[r] = 0; m_arch[r] = '0; m_pv[r] = 0;
                m_ptag[r] = '0; m_pdata[r] = '0;
            end
            m_cnt = '0; m_rv = '0;
            m_rd[0] = '0; m_rd[1] = '0; m_rt[0] = '0; m_rt[1] = '0;
        end else if (flash) begin
            for (int j = 0; j < 2; j++)
                if (cmt_en[j] && cmt_logic[j] != 0)
                    m_arch[cmt_logic[j]] = cmt_data[j];
            for (int r = 0; r < NREG; r++) m_place[r] = 0;
            m_cnt = '0; m_rv = '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                est[k] = comp_en[k] && comp_logic[k] != 0
                      && m_place[comp_logic[k]] && !m_pv[comp_logic[k]]
                      && m_ptag[comp_logic[k]] == comp_tag[k];
            end
            for (int i = 0; i < 2; i++) begin
                int s;
                int hit;
                s = int'(src[i]);
                hit = -1;
                for (int k = 1; k >= 0; k--)
                    if (est[k] && int'(comp_logic[k]) == s) hit = k;
                if (s == 0) begin vv = 1; val = '0; end
                else if (hit >= 0) begin vv = 1; val = comp_data[hit]; end
                else if (m_place[s]) begin vv = m_pv[s]; val = m_pdata[s]; end
                else begin vv = 1; val = m_arch[s]; end
                m_rv[i] = vv;
                if (vv) m_rd[i] = val;
                else m_rt[i] = m_ptag[s];
            end
            for (int j = 0; j < 2; j++) begin
                if (cmt_en[j] && cmt_logic[j] != 0) begin
                    m_arch[cmt_logic[j]] = cmt_data[j];
                    if (m_place[cmt_logic[j]] && m_ptag[cmt_logic[j]] == cmt_tag[j])
                        m_place[cmt_logic[j]] = 0;
                end
            end
            for (int k = 1; k >= 0; k--) begin
                if (est[k] && !(dest_en && dest_logic == comp_logic[k])) begin
                    m_pv[comp_logic[k]] = 1;
                    m_pdata[comp_logic[k]] = comp_data[k];
                end
            end
            // Applied last so a same-cycle rename overrides a commit clear.
            if (dest_en) begin
                if (dest_logic != 0) begin
                    m_place[dest_logic] = 1;
                    m_pv[dest_logic] = 0;
                    m_ptag[dest_logic] = m_cnt;
                end
                m_cnt = m_cnt + 1'b1;
            end
        end
        e.v = m_rv;
        e.d[0] = m_rd[0]; e.d[1] = m_rd[1];
        e.t[0] = m_rt[0]; e.t[1] = m_rt[1];
        q.push_back(e);
    endtask

    task automatic step();
        @(negedge clock);
        if (!reset) check("dest_phys", dest_phys == m_cnt, 64'(dest_phys), 64'(m_cnt));
        model_cycle();
        @(posedge clock);
        #2;
        reset = 0; flash = 0; dest_en = 0; comp_en = '0; cmt_en = '0;
    endtask

    always @(posedge clock) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            for (int i = 0; i < 2; i++) begin
                check("rd_valid", rd_valid[i] == e.v[i], 64'(rd_valid[i]), 64'(e.v[i]));
                check("rd_data", rd_data[i] == e.d[i], 64'(rd_data[i]), 64'(e.d[i]));
                check("rd_tag", rd_tag[i] == e.t[i], 64'(rd_tag[i]), 64'(e.t[i]));
            end
        end
    end

    task automatic rand_stim();
        reset = ($urandom_range(0, 299) == 0);
        flash = ($urandom_range(0, 59) == 0);
        dest_en = $urandom_range(0, 1);
        dest_logic = LW'($urandom_range(0, NREG - 1));
        for (int i = 0; i < 2; i++) src[i] = LW'($urandom_range(0, NREG - 1));
        for (int k = 0; k < 2; k++) begin
            comp_en[k] = $urandom_range(0, 1);
            comp_logic[k] = LW'($urandom_range(0, NREG - 1));
            comp_tag[k] = ($urandom_range(0, 3) != 0) ? m_ptag[comp_logic[k]]
                                                      : TW'($urandom);
            comp_data[k] = $urandom;
        end
        for (int j = 0; j < 2; j++) begin
            cmt_en[j] = $urandom_range(0, 1);
            cmt_logic[j] = LW'($urandom_range(0, NREG - 1));
            cmt_tag[j] = ($urandom_range(0, 1) != 0) ? m_ptag[cmt_logic[j]]
                                                     : TW'($urandom);
            cmt_data[j] = $urandom;
            for (int k = 0; k < 2; k++)
                if (comp_en[k] && comp_logic[k] == cmt_logic[j]
                    && comp_tag[k] == cmt_tag[j])
                    cmt_en[j] = 0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running required finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1; src[0] = 5; src[1] = 0;
        step();
        step();
        check("rst rd5 valid", rd_valid[0] == 1'b1, 64'(rd_valid[0]), 1);
        check("rst rd5 data", rd_data[0] == 0, 64'(rd_data[0]), 0);
        check("first tag", dest_phys == 0, 64'(dest_phys), 0);
        dest_en = 1; dest_logic = 5;
        step();
        step();
        check("ren5 valid", rd_valid[0] == 1'b0, 64'(rd_valid[0]), 0);
        check("ren5 tag", rd_tag[0] == 0, 64'(rd_tag[0]), 0);
        comp_en = 2'b01; comp_logic[0] = 5; comp_tag[0] = 0; comp_data[0] = 32'hDEAD;
        step();
        check("bypass data", rd_data[0] == 32'hDEAD, 64'(rd_data[0]), 64'hDEAD);
        step();
        check("stored data", rd_valid[0] && rd_data[0] == 32'hDEAD, 64'(rd_data[0]), 64'hDEAD);
        dest_en = 1; dest_logic = 7; step();
        dest_en = 1; dest_logic = 7; step();
        src[0] = 7; comp_en = 2'b01; comp_logic[0] = 7; comp_tag[0] = 1; comp_data[0] = 32'h77;
        step();
        check("stale comp", !rd_valid[0] && rd_tag[0] == 2, 64'(rd_tag[0]), 2);
        cmt_en = 2'b01; cmt_logic[0] = 7; cmt_tag[0] = 1; cmt_data[0] = 32'h11;
        step();
        step();
        check("old commit", !rd_valid[0] && rd_tag[0] == 2, 64'(rd_tag[0]), 2);
        cmt_en = 2'b10; cmt_logic[1] = 7; cmt_tag[1] = 2; cmt_data[1] = 32'h22;
        step();
        step();
        check("arch return", rd_valid[0] && rd_data[0] == 32'h22, 64'(rd_data[0]), 64'h22);
        dest_en = 1; dest_logic = 3; step();
        src[0] = 3;
        dest_en = 1; dest_logic = 3;
        comp_en = 2'b10; comp_logic[1] = 3; comp_tag[1] = 3; comp_data[1] = 32'h33;
        step();
        check("bypass same cyc", rd_valid[0] && rd_data[0] == 32'h33, 64'(rd_data[0]), 64'h33);
        step();
        check("rename wins", !rd_valid[0] && rd_tag[0] == 4, 64'(rd_tag[0]), 4);
        dest_en = 1; dest_logic = 4; step();
        flash = 1; cmt_en = 2'b01; cmt_logic[0] = 4; cmt_tag[0] = 9; cmt_data[0] = 32'h44;
        src[0] = 4;
        step();
        check("flash rd_valid", rd_valid == 2'b00, 64'(rd_valid), 0);
        step();
        check("flash arch", rd_valid[0] && rd_data[0] == 32'h44, 64'(rd_data[0]), 64'h44);
        check("flash counter", dest_phys == 0, 64'(dest_phys), 0);
        for (int n = 0; n < 16; n++) begin
            dest_en = 1; dest_logic = 9; step();
        end
        check("tag wrap", dest_phys == 0, 64'(dest_phys), 0);
        dest_en = 1; dest_logic = 0; src[1] = 0; step();
        check("zr counter", dest_phys == 1, 64'(dest_phys), 1);
        step();
        check("zr valid", rd_valid[1] && rd_data[1] == 0, 64'(rd_data[1]), 0);
        for (int n = 0; n < 3000; n++) begin
            rand_stim();
            step();
        end
        @(posedge clock);
        #3;
        check("queue drained", q.size() == 0, 64'(q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
